// File: rtl/mode_set_ctrl.sv
// Digital-clock mode sequencer: debounces three push-buttons, steps run/set-time/
// show-alarm/set-alarm, edits a time snapshot and owns the alarm registers.
module mode_set_ctrl #(
  parameter int         DEBOUNCE_CYCLES   = 250,
  parameter int         TIMEOUT_CYCLES    = 5000,
  parameter logic [7:0] ALARM_HOUR_INIT   = 8'd7,
  parameter logic [7:0] ALARM_MINUTE_INIT = 8'd0,
  parameter logic [7:0] ALARM_SECOND_INIT = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_sel_n,
  input  logic       key_inc_n,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  output logic [3:0] state_mode,
  output logic [1:0] set_field,
  output logic       time_load,
  output logic [7:0] load_hour,
  output logic [7:0] load_minute,
  output logic [7:0] load_second,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_minute,
  output logic [7:0] alarm_second
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SET_TIME   = 2'd1,
    SHOW_ALARM = 2'd2,
    SET_ALARM  = 2'd3
  } mode_t;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  // Key vectors are ordered {inc, sel, mode}; all levels active-low.
  logic [2:0]    raw_n;
  logic [2:0]    sync1_n;
  logic [2:0]    sync2_n;
  logic [2:0]    db_n;
  logic [2:0]    db_d_n;
  logic [2:0]    ev;
  logic [DW-1:0] db_cnt [3];

  assign raw_n = {key_inc_n, key_sel_n, key_mode_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_n <= 3'b111;
      sync2_n <= 3'b111;
      db_n    <= 3'b111;
      db_d_n  <= 3'b111;
      ev      <= 3'b000;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
      db_d_n  <= db_n;
      ev      <= db_d_n & ~db_n;
      // The counter holds the number of consecutive mismatching cycles seen so far.
      for (int k = 0; k < 3; k++) begin
        if (sync2_n[k] != db_n[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            db_n[k]   <= sync2_n[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DW'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  logic ev_mode, ev_sel, ev_inc;
  assign ev_mode = ev[0];
  assign ev_sel  = ev[1];
  assign ev_inc  = ev[2];

  function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? 8'd0 : v + 8'd1;
  endfunction

  mode_t         state, state_nx;
  logic [1:0]    field_nx;
  logic          time_load_nx;
  logic [7:0]    ld_h_nx, ld_m_nx, ld_s_nx;
  logic [7:0]    al_h_nx, al_m_nx, al_s_nx;
  logic [IW-1:0] idle, idle_nx;
  logic          editing;

  assign editing    = (state == SET_TIME) || (state == SET_ALARM);
  assign state_mode = {2'b00, state};

  always_comb begin
    state_nx     = state;
    field_nx     = set_field;
    time_load_nx = 1'b0;
    ld_h_nx      = load_hour;
    ld_m_nx      = load_minute;
    ld_s_nx      = load_second;
    al_h_nx      = alarm_hour;
    al_m_nx      = alarm_minute;
    al_s_nx      = alarm_second;
    idle_nx      = '0;
    // Mode outranks sel, which outranks inc; lower-priority events are dropped.
    if (ev_mode) begin
      unique case (state)
        RUN: begin
          state_nx = SET_TIME;
          field_nx = 2'd0;
          ld_h_nx  = cur_hour;
          ld_m_nx  = cur_minute;
          ld_s_nx  = cur_second;
        end
        SET_TIME: begin
          state_nx     = SHOW_ALARM;
          time_load_nx = 1'b1;
        end
        SHOW_ALARM: begin
          state_nx = SET_ALARM;
          field_nx = 2'd0;
        end
        default: state_nx = RUN;
      endcase
    end else if (editing) begin
      if (ev_sel) begin
        field_nx = (set_field >= 2'd2) ? 2'd0 : set_field + 2'd1;
      end else if (ev_inc) begin
        if (state == SET_TIME) begin
          case (set_field)
            2'd0:    ld_s_nx = inc_wrap(load_second, 8'd59);
            2'd1:    ld_m_nx = inc_wrap(load_minute, 8'd59);
            2'd2:    ld_h_nx = inc_wrap(load_hour, 8'd23);
            default: ;
          endcase
        end else begin
          case (set_field)
            2'd0:    al_s_nx = inc_wrap(alarm_second, 8'd59);
            2'd1:    al_m_nx = inc_wrap(alarm_minute, 8'd59);
            2'd2:    al_h_nx = inc_wrap(alarm_hour, 8'd23);
            default: ;
          endcase
        end
      end else if (idle == IDLE_MAX) begin
        // Abandon without committing; alarm edits are already live.
        state_nx = RUN;
      end else begin
        idle_nx = idle + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      set_field    <= 2'd0;
      time_load    <= 1'b0;
      load_hour    <= 8'd0;
      load_minute  <= 8'd0;
      load_second  <= 8'd0;
      alarm_hour   <= ALARM_HOUR_INIT;
      alarm_minute <= ALARM_MINUTE_INIT;
      alarm_second <= ALARM_SECOND_INIT;
      idle         <= '0;
    end else begin
      state        <= state_nx;
      set_field    <= field_nx;
      time_load    <= time_load_nx;
      load_hour    <= ld_h_nx;
      load_minute  <= ld_m_nx;
      load_second  <= ld_s_nx;
      alarm_hour   <= al_h_nx;
      alarm_minute <= al_m_nx;
      alarm_second <= al_s_nx;
      idle         <= idle_nx;
    end
  end

endmodule

// File: doc/mode_set_ctrl.md
# mode_set_ctrl

Mode sequencer and time/alarm setting controller for the digital clock. It debounces three push-buttons and steps the 4-bit `state_mode` consumed by the timekeeper and display: 0 run, 1 set time, 2 show alarm, 3 set alarm. It edits a time snapshot and commits it to the timekeeper with a one-cycle load pulse. It also owns the alarm hour, minute and second registers.

## Interface
- `DEBOUNCE_CYCLES`, 250: consecutive stable synchronized samples required to accept a key level change.
- `TIMEOUT_CYCLES`, 5000: idle cycles in mode 1 or 3 before an automatic return to mode 0.
- `ALARM_HOUR_INIT` / `ALARM_MINUTE_INIT` / `ALARM_SECOND_INIT`, 7 / 0 / 0: alarm reset values.
- `clk`  in  1  system clock; the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_mode_n` / `key_sel_n` / `key_inc_n`  in  1 each  raw push-buttons, active-low, asynchronous to `clk`.
- `cur_hour` / `cur_minute` / `cur_second`  in  8 each  binary live time from the timekeeper.
- `state_mode`  out  4  0 run, 1 set time, 2 show alarm, 3 set alarm.
- `set_field`  out  2  edited field: 0 second, 1 minute, 2 hour.
- `time_load`  out  1  one-cycle pulse that commits `load_*` to the timekeeper.
- `load_hour` / `load_minute` / `load_second`  out  8 each  time edit registers.
- `alarm_hour` / `alarm_minute` / `alarm_second`  out  8 each  alarm registers.

## Operation
- Key path, per key:
  - 2-FF synchronizer feeds a debounce counter.
  - The debounced level flips only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A mismatch-free cycle clears the counter.
  - The debounced released→pressed transition produces a one-cycle event `ev_mode`, `ev_sel` or `ev_inc`. Release produces no event.
- Simultaneous events in one cycle: only the highest-priority event is acted on, and the others are dropped. Priority is mode > sel > inc.
- Mode FSM, advanced by `ev_mode`:
  - RUN(0) → SET_TIME(1) → SHOW_ALARM(2) → SET_ALARM(3) → RUN(0).
- Entering SET_TIME:
  - `load_*` ← `cur_*`, captured in the same cycle as the transition.
  - `set_field` ← 0.
- Leaving SET_TIME by `ev_mode`: `time_load` = 1 for exactly one cycle, coincident with `state_mode` becoming 2.
- Entering SET_ALARM: `set_field` ← 0.
- In modes 1 and 3:
  - `ev_sel` cycles `set_field` 0→1→2→0.
  - `ev_inc` increments the selected field of `load_*` (mode 1) or `alarm_*` (mode 3).
  - Wrap rules: second 59→0, minute 59→0, hour 23→0.
  - Increments never carry into the next field.
- In modes 0 and 2: `ev_sel` and `ev_inc` are ignored.
- Idle timeout:
  - An idle counter runs in modes 1 and 3 and clears on any event.
  - When it reaches `TIMEOUT_CYCLES`, the mode becomes 0 and no `time_load` is issued: SET_TIME edits are discarded.
  - Alarm edits already made stay in effect.
- Reset values: `state_mode` 0, `set_field` 0, `time_load` 0, `load_*` 0, `alarm_*` = `*_INIT`, debounced levels released, all counters 0.
- Reset mid-edit: all state returns to reset values immediately, and no `time_load` pulse is produced.
- Arithmetic: all fields are 8-bit unsigned binary. The upper bits stay 0 for legal values. Increment is compare-then-wrap, never modulo-256.

## Timing
- All outputs are registered.
- Raw key edge to output change: 2 sync cycles, plus `DEBOUNCE_CYCLES` stable cycles, plus 1 cycle for the event register, plus 1 cycle for the output register.
  - Nominal latency is `DEBOUNCE_CYCLES`+4 cycles, with a ±1 cycle tolerance for synchronizer phase.
- `time_load` is high for exactly one cycle per commit. `load_*` values are stable on that cycle and hold until the next SET_TIME entry.
- Idle timeout fires on the cycle the counter equals `TIMEOUT_CYCLES`. `state_mode` reads 0 on the following cycle.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event.

## Test plan
- Reset release, no keys → `state_mode`=0, `set_field`=0, `alarm_*`=07:00:00, `time_load`=0.
- `cur`=10:20:30 with `DEBOUNCE_CYCLES`=4:
  - Stimulus: press mode, sel, inc ×3, mode.
  - Response: `state_mode` 0→1→2, `load_*`=10:23:30, a single `time_load` pulse when `state_mode` becomes 2.
- Mode 3 with `set_field`=2 and `alarm_hour`=23:
  - Stimulus: `ev_inc`.
  - Response: `alarm_hour`=0, `alarm_minute` unchanged.
  - Sequence sel→sel→sel returns `set_field` to 2.
- Key bouncing at 3-cycle intervals with `DEBOUNCE_CYCLES`=4 → no event. A 10-cycle-stable press → exactly one event.
- Mode 1 with edited `load_*` and no keys for `TIMEOUT_CYCLES`=100 → `state_mode`=0 and no `time_load` pulse.
- Mode and inc pressed in the same cycle in mode 1 → mode advances to 2 and the increment is dropped. `rst` asserted mid-edit → all outputs return to reset values with no `time_load` pulse.
